// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared command codes, sequencer states and default geometry for the conv1d sequencer.
package conv1d_pkg;
   localparam int DEF_KERNEL_LENGTH = 8;
   localparam int DEF_PADDING = 4;
   localparam int DEF_MAX_DEPTH = 128;
   localparam int DEF_MAX_WIDTH = 1024;
   localparam logic [6:0] CMD_WR_INPUT = 7'd10;
   localparam logic [6:0] CMD_WR_KERNEL = 7'd11;
   localparam logic [6:0] CMD_OFFSET = 7'd20;
   localparam logic [6:0] CMD_WIDTH = 7'd25;
   localparam logic [6:0] CMD_DEPTH = 7'd26;
   localparam logic [6:0] CMD_COMPUTE = 7'd41;
   localparam logic [6:0] CMD_READ_ACC = 7'd43;
   localparam logic [6:0] CMD_START_X = 7'd44;
   typedef enum logic [3:0] {
      IDLE, REJECT, CFG_OFF, CFG_WID, CFG_DEP, PREFILL,
      SETX, COMPUTE, READ, CAPTURE, EMIT, LOAD, FINISH
   } state_t;
endpackage

// File: rtl/conv1d_col_writer.sv
// conv1d_col_writer: writes one window column of depth bytes (pad byte or streamed input) as cmd 10 writes.
module conv1d_col_writer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic [31:0] slot,
   input  logic [31:0] depth,
   input  logic        pad,
   input  logic [7:0]  pad_byte,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr,
   output logic [31:0] addr,
   output logic [7:0]  data,
   output logic        col_done
);
   logic active, last, take;
   logic [31:0] ch;
   assign in_ready = active && !pad;
   assign take = active && (pad || in_valid);
   // done coincides with the last write being presented, so the caller's next command never collides
   assign col_done = wr && last;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active <= 1'b0;
         last <= 1'b0;
         wr <= 1'b0;
         ch <= '0;
         addr <= '0;
         data <= '0;
      end else begin
         wr <= take;
         if (take) begin
            addr <= slot * depth + ch;
            data <= pad ? pad_byte : in_data;
            last <= ch == depth - 1;
            ch <= ch == depth - 1 ? '0 : ch + 1;
         end
         if (go) begin
            active <= 1'b1;
            ch <= '0;
         end else if (take && ch == depth - 1) begin
            active <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/conv1d_sequencer.sv
// conv1d_sequencer: drives the conv1d datapath command port from a layer config and an input byte stream,
// keeping the circular 8-column window filled with same-padding and streaming one accumulator per output.
module conv1d_sequencer
   import conv1d_pkg::*;
#(
   parameter int KERNEL_LENGTH = DEF_KERNEL_LENGTH,
   parameter int PADDING = DEF_PADDING,
   parameter int MAX_DEPTH = DEF_MAX_DEPTH,
   parameter int MAX_WIDTH = DEF_MAX_WIDTH
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] cfg_depth,
   input  logic [31:0] cfg_width,
   input  logic [31:0] cfg_offset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [6:0]  cu_cmd,
   output logic [31:0] cu_inp0,
   output logic [31:0] cu_inp1,
   input  logic [31:0] cu_ret
);
   state_t state, next;
   logic [31:0] depth, width, offset, col, p, slot, neg_off, wr_addr;
   logic [7:0] wr_data;
   logic loaded, go, pad, bad, last_out, wr, col_done;
   assign bad = cfg_depth == 0 || cfg_depth > MAX_DEPTH || cfg_width == 0 || cfg_width > MAX_WIDTH;
   assign pad = col < PADDING || col >= width + PADDING;
   assign slot = col % KERNEL_LENGTH;
   assign neg_off = -offset;
   assign last_out = p == width - 1;
   conv1d_col_writer u_col (
      .clk(clk), .rst_n(rst_n), .go(go), .slot(slot), .depth(depth), .pad(pad),
      .pad_byte(neg_off[7:0]), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr(wr), .addr(wr_addr), .data(wr_data), .col_done(col_done)
   );
   // the next column load starts at CAPTURE so it overlaps the result handshake
   always_comb begin
      next = state;
      go = 1'b0;
      case (state)
         IDLE: next = start ? (bad ? REJECT : CFG_OFF) : IDLE;
         REJECT: next = IDLE;
         CFG_OFF: next = CFG_WID;
         CFG_WID: next = CFG_DEP;
         CFG_DEP: begin
            next = PREFILL;
            go = 1'b1;
         end
         PREFILL: begin
            next = col_done && col == KERNEL_LENGTH - 1 ? SETX : PREFILL;
            go = col_done && col != KERNEL_LENGTH - 1;
         end
         SETX: next = COMPUTE;
         COMPUTE: next = READ;
         READ: next = CAPTURE;
         CAPTURE: begin
            next = EMIT;
            go = !last_out;
         end
         EMIT: next = out_ready ? (last_out ? FINISH : LOAD) : EMIT;
         LOAD: next = loaded || col_done ? SETX : LOAD;
         FINISH: next = IDLE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         depth <= '0;
         width <= '0;
         offset <= '0;
         col <= '0;
         p <= '0;
         out_data <= '0;
         err <= 1'b0;
         loaded <= 1'b0;
      end else begin
         state <= next;
         if (state == IDLE && start) begin
            depth <= cfg_depth;
            width <= cfg_width;
            offset <= cfg_offset;
            col <= '0;
            p <= '0;
            err <= bad;
         end
         if (col_done) loaded <= 1'b1;
         if (go) loaded <= 1'b0;
         if (go && state != CFG_DEP) col <= col + 1;
         if (state == CAPTURE) out_data <= cu_ret;
         if (state == EMIT && out_ready) p <= p + 1;
      end
   end
   always_comb begin
      busy = !(state inside {IDLE, REJECT, FINISH});
      done = state inside {REJECT, FINISH};
      out_valid = state == EMIT;
      cu_cmd = wr ? CMD_WR_INPUT :
               state == CFG_OFF ? CMD_OFFSET :
               state == CFG_WID ? CMD_WIDTH :
               state == CFG_DEP ? CMD_DEPTH :
               state == SETX ? CMD_START_X :
               state == COMPUTE ? CMD_COMPUTE :
               state == READ ? CMD_READ_ACC : 7'd0;
      cu_inp0 = wr ? wr_addr : '0;
      cu_inp1 = wr ? {{24{wr_data[7]}}, wr_data} :
                state == CFG_OFF ? offset :
                state == CFG_WID ? width :
                state == CFG_DEP ? depth :
                state == SETX ? p % KERNEL_LENGTH : '0;
   end
endmodule

// File: tb/tb_conv1d_sequencer.sv
// tb_conv1d_sequencer: datapath model plus scoreboard bench for the conv1d sequencer.
module tb_conv1d_sequencer;
   logic clk, rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done, err;
   logic [31:0] cfg_depth, cfg_width, cfg_offset, out_data, cu_inp0, cu_inp1;
   logic [31:0] cu_ret = '0;
   logic [7:0] in_data;
   logic [6:0] cu_cmd;
   int checks = 0, errors = 0, stall_n = 0, accepted = 0, n_out = 0, wait_cnt = 0;
   bit gaps = 0;
   logic [31:0] exp_q[$];
   logic [7:0] byte_q[$];
   logic [31:0] cmd_log[$], val_log[$];
   int wt [8][128];
   logic [7:0] mem [1024];
   logic [31:0] m_off = '0, m_sx = '0, m_depth = '0, acc = '0;
   int s1_exp [10] = '{10, 15, 21, 28, 36, 44, 52, 49, 45, 40};

   conv1d_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_depth(cfg_depth), .cfg_width(cfg_width),
      .cfg_offset(cfg_offset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
      .done(done), .err(err), .cu_cmd(cu_cmd), .cu_inp0(cu_inp0), .cu_inp1(cu_inp1), .cu_ret(cu_ret)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, $signed(act), $signed(want));
      end
   endtask

   // datapath model: window memory, offset, start column, accumulator
   function automatic int dp_compute();
      int s = 0;
      for (int k = 0; k < 8; k++)
         for (int ch = 0; ch < int'(m_depth); ch++) begin
            logic [9:0] ix;
            ix = 10'(((int'(m_sx) + k) % 8) * int'(m_depth) + ch);
            s += (int'($signed(mem[ix])) + int'(m_off)) * wt[k][ch];
         end
      return s;
   endfunction

   always @(posedge clk) begin
      case (cu_cmd)
         7'd10: mem[cu_inp0[9:0]] <= cu_inp1[7:0];
         7'd20: m_off <= cu_inp1;
         7'd26: m_depth <= cu_inp1;
         7'd44: m_sx <= cu_inp1;
         7'd41: acc <= dp_compute();
         7'd43: cu_ret <= acc;
         default: ;
      endcase
   end

   function automatic void golden(input int d, input int w, input int off, input logic [7:0] ins[$]);
      for (int p = 0; p < w; p++) begin
         int s = 0;
         for (int k = 0; k < 8; k++)
            for (int ch = 0; ch < d; ch++) begin
               int idx = p + k;
               int v = (idx < 4 || idx >= w + 4) ? 0 : int'($signed(ins[(idx - 4) * d + ch])) + off;
               s += v * wt[k][ch];
            end
         exp_q.push_back(s);
      end
   endfunction

   task automatic set_wt(input int mode);
      for (int k = 0; k < 8; k++)
         for (int ch = 0; ch < 128; ch++) wt[k][ch] = mode == 0 ? 1 : (k - 3) + ch;
   endtask

   // input byte feeder
   initial begin
      bit hs;
      in_valid = 0;
      in_data = 0;
      forever begin
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (hs && byte_q.size() > 0) begin
            void'(byte_q.pop_front());
            accepted++;
         end
         if (byte_q.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
            in_valid = 1;
            in_data = byte_q[0];
         end else in_valid = 0;
      end
   end

   // result back-pressure
   initial begin
      out_ready = 1;
      forever begin
         @(posedge clk);
         #1;
         if (out_valid && wait_cnt < stall_n) begin
            out_ready = 0;
            wait_cnt++;
         end else begin
            out_ready = 1;
            wait_cnt = 0;
         end
      end
   end

   // result monitor and stall stability
   initial begin
      bit stalled = 0;
      logic [31:0] held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) stalled = 0;
         else if (out_valid) begin
            if (stalled) chk("stall_stable", out_data, held);
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_result got %0d want none", $signed(out_data));
               end else chk("result", out_data, exp_q.pop_front());
               n_out++;
               stalled = 0;
            end else begin
               stalled = 1;
               held = out_data;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (cu_cmd != 0) begin
            cmd_log.push_back(32'(cu_cmd));
            val_log.push_back(cu_inp1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic pulse_start(input int d, input int w, input int off);
      @(posedge clk);
      #1;
      cfg_depth = d;
      cfg_width = w;
      cfg_offset = off;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 4000);
      chk(tag, 32'(done), 1);
      @(negedge clk);
      chk("done_pulse", 32'(done), 0);
      chk("busy_after", 32'(busy), 0);
   endtask

   task automatic run_job(input int d, input int w, input int off, input string tag);
      pulse_start(d, w, off);
      @(negedge clk);
      chk("busy", 32'(busy), 1);
      wait_done(tag);
   endtask

   task automatic load_s1();
      set_wt(0);
      for (int i = 1; i <= 10; i++) byte_q.push_back(8'(i));
      for (int i = 0; i < 10; i++) exp_q.push_back(s1_exp[i]);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cmd"}, 32'(cu_cmd), 0);
      chk({tag, "_inp0"}, cu_inp0, 0);
      chk({tag, "_inp1"}, cu_inp1, 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
   endtask

   initial begin
      int mark, base, hs_seen, n;
      logic [7:0] s3_in[$];
      rst_n = 0;
      start = 0;
      cfg_depth = 0;
      cfg_width = 0;
      cfg_offset = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk);
      #1;
      rst_n = 1;

      load_s1();
      run_job(1, 10, 0, "s1_done");
      chk("s1_drained", 32'(exp_q.size()), 0);

      mark = cmd_log.size();
      byte_q.push_back(8'd0);
      exp_q.push_back(32'd5);
      run_job(1, 1, 5, "s2_done");
      chk("s2_cmd0", cmd_log[mark], 20);
      chk("s2_val0", val_log[mark], 5);
      chk("s2_cmd1", cmd_log[mark + 1], 25);
      chk("s2_val1", val_log[mark + 1], 1);
      chk("s2_cmd2", cmd_log[mark + 2], 26);
      chk("s2_val2", val_log[mark + 2], 1);

      set_wt(1);
      s3_in = '{8'd3, 8'hff, 8'd4, 8'd1, 8'hfb, 8'd9, 8'd2, 8'hfa};
      golden(2, 4, 2, s3_in);
      foreach (s3_in[i]) byte_q.push_back(s3_in[i]);
      byte_q.push_back(8'd77);
      byte_q.push_back(8'd78);
      gaps = 1;
      stall_n = 5;
      base = accepted;
      run_job(2, 4, 2, "s3_done");
      chk("s3_bytes", 32'(accepted - base), 8);
      chk("s3_drained", 32'(exp_q.size()), 0);
      gaps = 0;
      stall_n = 0;
      byte_q.delete();
      repeat (3) @(posedge clk);

      mark = cmd_log.size();
      pulse_start(0, 4, 0);
      @(negedge clk);
      chk("rej_d_err", 32'(err), 1);
      chk("rej_d_done", 32'(done), 1);
      chk("rej_d_busy", 32'(busy), 0);
      @(negedge clk);
      chk("rej_d_done_fall", 32'(done), 0);
      pulse_start(1, 1025, 0);
      @(negedge clk);
      chk("rej_w_err", 32'(err), 1);
      chk("rej_w_done", 32'(done), 1);
      @(negedge clk);
      chk("rej_w_done_fall", 32'(done), 0);
      chk("rej_no_cmds", 32'(cmd_log.size() - mark), 0);

      load_s1();
      pulse_start(1, 10, 0);
      @(negedge clk);
      chk("s5_err_cleared", 32'(err), 0);
      hs_seen = 0;
      n = 0;
      while (hs_seen < 4 && n < 2000) begin
         if (out_valid && out_ready) hs_seen++;
         if (hs_seen < 4) @(negedge clk);
         n++;
      end
      chk("s5_reach_out3", 32'(hs_seen), 4);
      @(posedge clk);
      #1;
      rst_n = 0;
      exp_q.delete();
      byte_q.delete();
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("midreset");
      @(posedge clk);
      #1;
      rst_n = 1;
      load_s1();
      run_job(1, 10, 0, "s5_rerun_done");
      chk("s5_drained", 32'(exp_q.size()), 0);

      load_s1();
      base = n_out;
      pulse_start(1, 10, 0);
      n = 0;
      while (n_out < base + 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      pulse_start(0, 5, 9);
      wait_done("s6_done");
      chk("s6_err", 32'(err), 0);
      chk("s6_count", 32'(n_out - base), 10);
      chk("s6_drained", 32'(exp_q.size()), 0);
      repeat (5) @(negedge clk);
      chk("s6_idle_busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
